// File: rtl/circuit_test_sequencer_pkg.sv
// Shared types and sizing constants for the circuit test sequencer.
package circuit_test_sequencer_pkg;

   localparam int unsigned VEC_COUNT = 32;
   localparam int unsigned VEC_W     = $clog2(VEC_COUNT);
   localparam int unsigned SIG_W     = 32;
   localparam int unsigned SEL_W     = 5;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      EMIT,
      DONE
   } state_e;

endpackage

// File: rtl/circuit_test_sequencer_sync2.sv
// Two-flop synchroniser bringing the asynchronous circuit output into the clock domain.
module sync2 (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/circuit_test_sequencer.sv
// Sweeps every circuit through all stimulus vectors, folds the sampled responses
// into a per-circuit signature and hands each signature out over a valid/ready port.
module circuit_test_sequencer
   import circuit_test_sequencer_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned NUM_CIRCUITS  = 32
) (
   input  logic             CLOCK_50,
   input  logic             RESET_N,
   input  logic             start,
   input  logic             abort,
   input  logic             dut_out,
   output logic [SEL_W-1:0] sel,
   output logic [VEC_W-1:0] stim,
   output logic             busy,
   output logic             sig_valid,
   input  logic             sig_ready,
   output logic [SEL_W-1:0] sig_circuit,
   output logic [SIG_W-1:0] sig_data,
   output logic             done
);

   localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(VEC_COUNT - 1);
   localparam logic [SEL_W-1:0] LAST_CIRC   = SEL_W'(NUM_CIRCUITS - 1);

   state_e           state_q;
   logic [SEL_W-1:0] circuit_q;
   logic [VEC_W-1:0] vec_q;
   logic [7:0]       cnt_q;
   logic [SIG_W-2:0] sig_q;
   logic [SIG_W-1:0] sig_d;
   logic [SEL_W-1:0] sel_q;
   logic [VEC_W-1:0] stim_q;
   logic             busy_q;
   logic             sig_valid_q;
   logic [SEL_W-1:0] sig_circuit_q;
   logic [SIG_W-1:0] sig_data_q;
   logic             done_q;
   logic             dut_sync;

   sync2 u_sync (
      .clk_i  (CLOCK_50),
      .rst_ni (RESET_N),
      .d_i    (dut_out),
      .q_o    (dut_sync)
   );

   // The accumulator keeps one bit fewer than the signature: the final shift lands straight in sig_data.
   assign sig_d = {sig_q, dut_sync};

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q       <= IDLE;
         circuit_q     <= '0;
         vec_q         <= '0;
         cnt_q         <= '0;
         sig_q         <= '0;
         sel_q         <= '0;
         stim_q        <= '0;
         busy_q        <= 1'b0;
         sig_valid_q   <= 1'b0;
         sig_circuit_q <= '0;
         sig_data_q    <= '0;
         done_q        <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abort && state_q != IDLE) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            sig_valid_q <= 1'b0;
            stim_q      <= '0;
            cnt_q       <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start && !abort) begin
                     circuit_q <= '0;
                     vec_q     <= '0;
                     cnt_q     <= '0;
                     sig_q     <= '0;
                     sel_q     <= '0;
                     stim_q    <= '0;
                     busy_q    <= 1'b1;
                     state_q   <= SETTLE;
                  end
               end
               SETTLE: begin
                  if (cnt_q == SETTLE_LAST) begin
                     cnt_q   <= '0;
                     state_q <= SAMPLE;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               SAMPLE: begin
                  sig_q <= sig_d[SIG_W-2:0];
                  if (vec_q != LAST_VEC) begin
                     vec_q   <= vec_q + 1'b1;
                     stim_q  <= vec_q + 1'b1;
                     state_q <= SETTLE;
                  end else begin
                     sig_data_q    <= sig_d;
                     sig_circuit_q <= circuit_q;
                     sig_valid_q   <= 1'b1;
                     state_q       <= EMIT;
                  end
               end
               EMIT: begin
                  if (sig_ready) begin
                     sig_valid_q <= 1'b0;
                     if (circuit_q == LAST_CIRC) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                     end else begin
                        circuit_q <= circuit_q + 1'b1;
                        sel_q     <= circuit_q + 1'b1;
                        vec_q     <= '0;
                        stim_q    <= '0;
                        sig_q     <= '0;
                        state_q   <= SETTLE;
                     end
                  end
               end
               DONE: begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
               default: begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign sel         = sel_q;
   assign stim        = stim_q;
   assign busy        = busy_q;
   assign sig_valid   = sig_valid_q;
   assign sig_circuit = sig_circuit_q;
   assign sig_data    = sig_data_q;
   assign done        = done_q;

endmodule

// File: tb/tb_circuit_test_sequencer.sv
// Bench for circuit_test_sequencer: circuits are modelled as per-circuit truth tables and
// every record, vector step, stall and done pulse is checked against a signature model.
module tb_circuit_test_sequencer;

   localparam int unsigned S = 4;
   localparam int unsigned N = 32;
   localparam int unsigned P = 32 * (S + 1) + 1;

   typedef struct {
      logic [4:0]  c;
      logic [31:0] d;
   } rec_t;

   logic        CLOCK_50 = 1'b0;
   logic        RESET_N;
   logic        start;
   logic        abort;
   logic        dut_out;
   logic        sig_ready;
   logic [4:0]  sel;
   logic [4:0]  stim;
   logic [4:0]  sig_circuit;
   logic [31:0] sig_data;
   logic        busy;
   logic        sig_valid;
   logic        done;

   logic [31:0] lut [32];
   logic [31:0] got_data [32];
   rec_t        exp_q [$];

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned hs_count = 0;
   int unsigned done_count = 0;
   int unsigned busy_cycles = 0;
   bit          hold_ready = 1'b0;
   int unsigned ready_mode = 0;

   logic        prev_busy, prev_valid, prev_ready, prev_abort, prev_done;
   logic [4:0]  prev_sel, prev_stim, prev_circ;
   logic [31:0] prev_data;
   int unsigned ps, pc;
   bit          step_ok;

   circuit_test_sequencer #(.SETTLE_CYCLES(S), .NUM_CIRCUITS(N)) dut (
      .CLOCK_50    (CLOCK_50),
      .RESET_N     (RESET_N),
      .start       (start),
      .abort       (abort),
      .dut_out     (dut_out),
      .sel         (sel),
      .stim        (stim),
      .busy        (busy),
      .sig_valid   (sig_valid),
      .sig_ready   (sig_ready),
      .sig_circuit (sig_circuit),
      .sig_data    (sig_data),
      .done        (done)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Each circuit responds to vector v with bit v of its truth table.
   assign dut_out = lut[sel][stim];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // First vector ends up in the MSB, last vector in the LSB.
   function automatic logic [31:0] exp_sig(input int unsigned c);
      logic [31:0] acc;
      acc = '0;
      for (int unsigned v = 0; v < 32; v++) acc = acc * 2 + 32'(lut[c][v]);
      return acc;
   endfunction

   task automatic start_sweep();
      exp_q.delete();
      for (int unsigned c = 0; c < N; c++) begin
         exp_q.push_back('{c: 5'(c), d: exp_sig(c)});
         got_data[c] = 32'hDEAD_BEEF;
      end
      hs_count    = 0;
      done_count  = 0;
      busy_cycles = 0;
      start = 1'b1;
      @(posedge CLOCK_50); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input int unsigned max_cycles, input string what);
      int unsigned n;
      n = 0;
      while (busy && n < max_cycles) begin
         @(posedge CLOCK_50); #1;
         n++;
      end
      checks++;
      if (busy) begin
         errors++;
         $display("FAIL %s: busy=1 after %0d cycles, expected 0", what, n);
      end
   endtask

   initial begin
      sig_ready = 1'b0;
      forever begin
         @(posedge CLOCK_50); #1;
         if (hold_ready) sig_ready = 1'b0;
         else sig_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(3) != 0);
      end
   end

   always @(negedge CLOCK_50) begin
      if (!RESET_N) begin
         prev_busy  = 1'b0;
         prev_valid = 1'b0;
         prev_ready = 1'b0;
         prev_abort = 1'b0;
         prev_done  = 1'b0;
      end else begin
         if (busy && !prev_busy) begin
            chk("sweep_start_sel", 32'(sel), 0);
            chk("sweep_start_stim", 32'(stim), 0);
         end
         if (busy) busy_cycles++;
         if (prev_busy && busy && !prev_abort && (sel !== prev_sel || stim !== prev_stim)) begin
            ps = prev_stim;
            pc = prev_sel;
            step_ok = (sel == pc && stim == ps + 1) || (sel == pc + 1 && stim == 0 && ps == 31);
            checks++;
            if (!step_ok) begin
               errors++;
               $display("FAIL vector_order: sel/stim %0d/%0d -> %0d/%0d, expected next vector or next circuit at vector 0",
                        pc, ps, sel, stim);
            end
         end
         if (sig_valid) chk("valid_implies_busy", 32'(busy), 1);
         if (prev_valid && !prev_ready && !prev_abort) begin
            chk("stall_valid", 32'(sig_valid), 1);
            chk("stall_data", sig_data, prev_data);
            chk("stall_circuit", 32'(sig_circuit), 32'(prev_circ));
            chk("stall_sel", 32'(sel), 32'(prev_sel));
            chk("stall_stim", 32'(stim), 32'(prev_stim));
         end
         if (sig_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_record: circuit %0d data 0x%0h, expected no record", sig_circuit, sig_data);
            end else begin
               chk("record_circuit", 32'(sig_circuit), 32'(exp_q[0].c));
               chk("record_data", sig_data, exp_q[0].d);
               chk("record_sel", 32'(sel), 32'(exp_q[0].c));
               chk("record_stim", 32'(stim), 31);
               if (sig_ready && !abort) begin
                  got_data[sig_circuit] = sig_data;
                  hs_count++;
                  void'(exp_q.pop_front());
               end
            end
         end
         if (done) begin
            done_count++;
            chk("done_after_all_records", 32'(exp_q.size()), 0);
            chk("done_single_cycle", 32'(prev_done), 0);
         end
         prev_busy  = busy;
         prev_valid = sig_valid;
         prev_ready = sig_ready;
         prev_abort = abort;
         prev_done  = done;
         prev_sel   = sel;
         prev_stim  = stim;
         prev_circ  = sig_circuit;
         prev_data  = sig_data;
      end
   end

   initial begin
      logic [31:0] cap_data;
      logic [4:0]  cap_circ, cap_sel, cap_stim;
      int unsigned n;

      RESET_N = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      for (int c = 0; c < 32; c++) lut[c] = '0;
      #12;
      chk("reset_sel", 32'(sel), 0);
      chk("reset_stim", 32'(stim), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_sig_valid", 32'(sig_valid), 0);
      chk("reset_sig_circuit", 32'(sig_circuit), 0);
      chk("reset_sig_data", sig_data, 0);
      chk("reset_done", 32'(done), 0);
      @(posedge CLOCK_50); #1;
      RESET_N = 1'b1;

      // start together with abort in IDLE must be refused
      start = 1'b1;
      abort = 1'b1;
      repeat (10) begin
         @(posedge CLOCK_50); #1;
         chk("start_abort_idle_busy", 32'(busy), 0);
      end
      start = 1'b0;
      abort = 1'b0;

      // stim[0] response on every circuit, no back-pressure
      for (int c = 0; c < 32; c++) lut[c] = 32'hAAAA_AAAA;
      ready_mode = 0;
      @(posedge CLOCK_50); #1;
      start_sweep();
      wait_idle(6000, "sweep_stim0");
      chk("stim0_records", hs_count, 32);
      chk("stim0_done_pulses", done_count, 1);
      chk("stim0_busy_cycles", busy_cycles, N * P + 1);
      chk("stim0_rec0", got_data[0], 32'h5555_5555);
      chk("stim0_rec31", got_data[31], 32'h5555_5555);

      // only circuit 7 responds high
      for (int c = 0; c < 32; c++) lut[c] = (c == 7) ? 32'hFFFF_FFFF : 32'h0;
      start_sweep();
      wait_idle(6000, "sweep_c7");
      chk("c7_records", hs_count, 32);
      chk("c7_rec7", got_data[7], 32'hFFFF_FFFF);
      chk("c7_rec6", got_data[6], 32'h0000_0000);
      chk("c7_rec8", got_data[8], 32'h0000_0000);

      // random circuits, first record stalled, then random back-pressure
      for (int c = 0; c < 32; c++) lut[c] = $urandom();
      hold_ready = 1'b1;
      ready_mode = 1;
      start_sweep();
      n = 0;
      while (!sig_valid && n < 2000) begin
         @(posedge CLOCK_50); #1;
         n++;
      end
      chk("stall_valid_reached", 32'(sig_valid), 1);
      cap_data = sig_data;
      cap_circ = sig_circuit;
      cap_sel  = sel;
      cap_stim = stim;
      repeat (20) begin
         @(posedge CLOCK_50); #1;
         chk("hold_valid", 32'(sig_valid), 1);
         chk("hold_data", sig_data, cap_data);
         chk("hold_circuit", 32'(sig_circuit), 32'(cap_circ));
         chk("hold_sel", 32'(sel), 32'(cap_sel));
         chk("hold_stim", 32'(stim), 32'(cap_stim));
      end
      chk("hold_no_handshake", hs_count, 0);
      hold_ready = 1'b0;
      wait_idle(20000, "sweep_random_ready");
      chk("rand_records", hs_count, 32);
      chk("rand_done_pulses", done_count, 1);

      // abort on circuit 3, vector 10
      for (int c = 0; c < 32; c++) lut[c] = $urandom();
      ready_mode = 0;
      start_sweep();
      n = 0;
      while (!(busy && sel == 5'd3 && stim == 5'd10) && n < 3000) begin
         @(posedge CLOCK_50); #1;
         n++;
      end
      chk("abort_point_reached", {22'd0, sel, stim}, {22'd0, 5'd3, 5'd10});
      abort = 1'b1;
      @(posedge CLOCK_50); #1;
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_sig_valid", 32'(sig_valid), 0);
      chk("abort_stim", 32'(stim), 0);
      chk("abort_records", hs_count, 3);
      repeat (5) begin
         @(posedge CLOCK_50); #1;
         chk("abort_no_done", 32'(done), 0);
         chk("abort_stays_idle", 32'(busy), 0);
      end
      chk("abort_done_pulses", done_count, 0);

      start_sweep();
      wait_idle(6000, "sweep_after_abort");
      chk("restart_records", hs_count, 32);
      chk("restart_done_pulses", done_count, 1);
      chk("restart_busy_cycles", busy_cycles, N * P + 1);

      // reset pulse mid-SETTLE
      start_sweep();
      n = 0;
      while (!(busy && stim == 5'd5) && n < 1000) begin
         @(posedge CLOCK_50); #1;
         n++;
      end
      chk("reset_point_reached", 32'(stim), 5);
      #2;
      RESET_N = 1'b0;
      #1;
      chk("midreset_sel", 32'(sel), 0);
      chk("midreset_stim", 32'(stim), 0);
      chk("midreset_busy", 32'(busy), 0);
      chk("midreset_sig_valid", 32'(sig_valid), 0);
      chk("midreset_sig_circuit", 32'(sig_circuit), 0);
      chk("midreset_sig_data", sig_data, 0);
      chk("midreset_done", 32'(done), 0);
      start = 1'b1;
      repeat (5) begin
         @(posedge CLOCK_50); #1;
         chk("start_in_reset_ignored", 32'(busy), 0);
      end
      start = 1'b0;
      RESET_N = 1'b1;
      repeat (3) begin
         @(posedge CLOCK_50); #1;
         chk("idle_after_reset", 32'(busy), 0);
      end

      for (int c = 0; c < 32; c++) lut[c] = $urandom();
      ready_mode = 1;
      start_sweep();
      wait_idle(20000, "sweep_after_reset");
      chk("final_records", hs_count, 32);
      chk("final_done_pulses", done_count, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
